dpram_port_arbiter: RTL and testbench
=====================================

# dpram_port_arbiter

Access controller between two independent requesters and the shared dual-port RAM (4-bit × 4-word default geometry, ports A/B, per-port write enable). It grants each requester its RAM port every cycle except on an address collision. A collision is both ports addressing the same word in the same cycle with at least one write. On a collision exactly one port is granted and the other is stalled. The block also registers read-data valid strobes and keeps a saturating collision counter for debug.

## Interface
- `DW`, 4, data width
- `AW`, 2, address width (RAM depth 2^AW)
- `CW`, 8, collision counter width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `a_req`, `b_req`  in  1  request valid, port A / B
- `a_we`, `b_we`  in  1  1 = write, 0 = read
- `a_addr`, `b_addr`  in  AW  word address
- `a_wdata`, `b_wdata`  in  DW  write data
- `a_gnt`, `b_gnt`  out  1  request accepted this cycle (combinational)
- `a_rvalid`, `b_rvalid`  out  1  read data valid (registered)
- `a_rdata`, `b_rdata`  out  DW  read data (pass-through of RAM dout)
- `ram_wea`, `ram_web`  out  1  to RAM write enables
- `ram_addra`, `ram_addrb`  out  AW  to RAM addresses
- `ram_dina`, `ram_dinb`  out  DW  to RAM write data
- `ram_douta`, `ram_doutb`  in  DW  from RAM, synchronous read, 1-cycle latency
- `coll_cnt`  out  CW  saturating count of collision cycles

## Operation
- Collision: `a_req & b_req & (a_addr == b_addr) & (a_we | b_we)`.
  - Two reads of the same address are not a collision. Both are granted.
- No collision: `x_gnt = x_req` for each port.
- Collision: the winner gets `gnt = 1`. The loser gets `gnt = 0`.
- Stalled requester handshake:
  - Holds `req`, `we`, `addr` and `wdata` stable until granted.
  - A request may not be withdrawn while stalled; behaviour is undefined if it is.
- Winner selection: a one-bit `last_win` register (0 = A won last, 1 = B won last).
  - The winner is the port that did not win last.
  - `last_win` updates only on collision cycles.
  - Reset value is 1, so A wins the first collision.
- RAM drive:
  - `ram_addrx = x_addr` and `ram_dinx = x_wdata`, always passed through.
  - `ram_wex = x_gnt & x_we`.
  - A stalled write therefore never reaches the RAM.
- Read return:
  - `x_rvalid` is set on the cycle after `x_gnt & ~x_we`.
  - `x_rdata = ram_doutx` (unregistered).
- Read of a word granted in the cycle after a write to it returns the new data. The RAM's write-before-next-read ordering is relied on.
- `coll_cnt` increments on each collision cycle and saturates at 2^CW−1. It never wraps.

## Timing
- Reset values (asserted asynchronously, released synchronously to `clk`):
  - `a_rvalid = b_rvalid = 0`
  - `coll_cnt = 0`
  - `last_win = 1`
  - `gnt` and `ram_we*` forced to 0 while `rst_n = 0`.
- Grant latency: 0 cycles without collision. With `RR_FAIR_EN`, the loser waits exactly 1 cycle.
- Read latency: `rvalid` and data 1 cycle after grant.
- Back-to-back grants are allowed on every cycle on both ports.
- Reset mid-operation:
  - A pending read's `rvalid` is dropped.
  - A stalled request must be re-issued after reset.
  - A write granted in the same cycle as reset assertion is not guaranteed.
- State elements: `last_win`, `a_rvalid`, `b_rvalid`, `coll_cnt`. No other registers.

## Configuration
- `RR_FAIR_EN` defined: round-robin selection via `last_win` as described.
  - Bounds starvation to 1 cycle.
- `RR_FAIR_EN` undefined: fixed priority, A always wins a collision.
  - `last_win` is not implemented.
  - B may starve while A keeps colliding.
  - `coll_cnt` behaviour is unchanged.

## Test plan
- Reset: `rst_n = 0` with `a_req = b_req = 1` → `gnt = 0`, `ram_we* = 0`, `rvalid = 0`, `coll_cnt = 0`.
- Non-colliding dual write: A writes addr 2 = 4'b1111 and B writes addr 3 = 4'b0010 in the same cycle.
  - Expect `a_gnt = b_gnt = 1` and both writes in the RAM.
  - Reads issued afterwards return 4'b1111 and 4'b0010 one cycle after grant.
- Write/write collision at addr 3 (A = 4'b0000, B = 4'b0110), held requests:
  - `RR_FAIR_EN`: A granted in cycle 0, B in cycle 1; a later read of addr 3 returns 4'b0110; `coll_cnt = 1`.
  - Without the macro: same order, but with A re-requesting continuously B never gets `gnt`.
- Read/write collision: A reads addr 1 while B writes 4'b0101 to addr 1, starting after reset.
  - A granted first and reads the old value.
  - A second collision the next cycle favours B under `RR_FAIR_EN`.
- Same-address dual read at addr 0 → both granted, `a_rvalid = b_rvalid = 1` next cycle with equal data, `coll_cnt` unchanged.
- Saturation: with `CW = 2`, force 5 collision cycles → `coll_cnt` reads 3 and holds.

Source files
------------

// File: rtl/dpram_port_arbiter.sv
// Access controller in front of a dual-port RAM: grants each requester its port, stalls one side
// on a same-word collision involving a write. Optional macro RR_FAIR_EN selects round-robin winner.
module dpram_port_arbiter #(
  parameter int DW = 4,
  parameter int AW = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          b_req,
  input  logic          a_we,
  input  logic          b_we,
  input  logic [AW-1:0] a_addr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          ram_wea,
  output logic          ram_web,
  output logic [AW-1:0] ram_addra,
  output logic [AW-1:0] ram_addrb,
  output logic [DW-1:0] ram_dina,
  output logic [DW-1:0] ram_dinb,
  input  logic [DW-1:0] ram_douta,
  input  logic [DW-1:0] ram_doutb,
  output logic [CW-1:0] coll_cnt
);

  // Handshake: a request transfers in the cycle where x_req & x_gnt; a stalled requester keeps
  // req/we/addr/wdata stable until granted. Read data follows with x_rvalid one cycle later.
  logic          w_coll;
  logic          w_a_wins;
  logic          w_a_gnt;
  logic          w_b_gnt;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [CW-1:0] r_coll_cnt;

  assign w_coll = a_req & b_req & (a_addr == b_addr) & (a_we | b_we);

`ifdef RR_FAIR_EN
  // 1 = B won the last collision, so A is favoured next; reset lets A win the first one.
  logic r_last_win;

  assign w_a_wins = r_last_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_win <= 1'b1;
    end else if (w_coll) begin
      r_last_win <= ~w_a_wins;
    end
  end
`else
  assign w_a_wins = 1'b1;
`endif

  // Grants are held low while reset is asserted so nothing reaches the RAM.
  assign w_a_gnt = rst_n & a_req & (~w_coll | w_a_wins);
  assign w_b_gnt = rst_n & b_req & (~w_coll | ~w_a_wins);

  assign a_gnt     = w_a_gnt;
  assign b_gnt     = w_b_gnt;
  assign ram_wea   = w_a_gnt & a_we;
  assign ram_web   = w_b_gnt & b_we;
  assign ram_addra = a_addr;
  assign ram_addrb = b_addr;
  assign ram_dina  = a_wdata;
  assign ram_dinb  = b_wdata;
  assign a_rdata   = ram_douta;
  assign b_rdata   = ram_doutb;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign coll_cnt  = r_coll_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_gnt & ~a_we;
      r_b_rvalid <= w_b_gnt & ~b_we;
    end
  end

  // Saturating debug counter: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll_cnt <= '0;
    end else if (w_coll && (r_coll_cnt != {CW{1'b1}})) begin
      r_coll_cnt <= r_coll_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed scenarios plus held-request random traffic against a
// behavioural model; read data is scoreboarded through per-port expected queues.
module tb_dpram_port_arbiter;

  localparam int DW    = 4;
  localparam int AW    = 2;
  localparam int CW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << CW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_wea, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_dinb;
  logic [DW-1:0] ram_douta, ram_doutb;
  logic [CW-1:0] coll_cnt;

  always #5 clk = ~clk;

  dpram_port_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_wea(ram_wea), .ram_web(ram_web), .ram_addra(ram_addra), .ram_addrb(ram_addrb),
    .ram_dina(ram_dina), .ram_dinb(ram_dinb), .ram_douta(ram_douta), .ram_doutb(ram_doutb),
    .coll_cnt(coll_cnt)
  );

  // Behavioural synchronous-read dual-port RAM attached to the DUT.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wea) ram_mem[ram_addra] <= ram_dina;
    if (ram_web) ram_mem[ram_addrb] <= ram_dinb;
    ram_douta <= ram_mem[ram_addra];
    ram_doutb <= ram_mem[ram_addrb];
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_last_b;   // B won the most recent collision
  int            m_coll;
  logic          m_a_stall, m_b_stall;
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];
  int            n_checks, n_errors;
  logic          mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic ar, input logic aw, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic br, input logic bw,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    logic coll, ga, gb;
    @(negedge clk);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    coll = ar & br & (aa == ba) & (aw | bw);
    if (!coll) begin
      ga = ar;
      gb = br;
    end else begin
`ifdef RR_FAIR_EN
      ga = m_last_b;
`else
      ga = 1'b1;
`endif
      gb = ~ga;
      m_last_b = gb;
      m_coll++;
    end
    #1;
    check("a_gnt", a_gnt, ga);
    check("b_gnt", b_gnt, gb);
    check("ram_wea", ram_wea, ga & aw);
    check("ram_web", ram_web, gb & bw);
    check("ram_addra", ram_addra, aa);
    check("ram_addrb", ram_addrb, ba);
    check("ram_dina", ram_dina, ad);
    check("ram_dinb", ram_dinb, bd);
    if (ga && !aw) exp_a_q.push_back(m_mem[aa]);
    if (gb && !bw) exp_b_q.push_back(m_mem[ba]);
    if (ga && aw) m_mem[aa] = ad;
    if (gb && bw) m_mem[ba] = bd;
    m_a_stall = ar & ~ga;
    m_b_stall = br & ~gb;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = '0; a_wdata = '1;
    b_req = 1'b1; b_we = 1'b1; b_addr = '0; b_wdata = '1;
    m_coll = 0; m_last_b = 1'b1; m_a_stall = 1'b0; m_b_stall = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    #1;
    check("rst_a_gnt", a_gnt, 1'b0);
    check("rst_b_gnt", b_gnt, 1'b0);
    check("rst_ram_wea", ram_wea, 1'b0);
    check("rst_ram_web", ram_web, 1'b0);
    check("rst_a_rvalid", a_rvalid, 1'b0);
    check("rst_b_rvalid", b_rvalid, 1'b0);
    check("rst_coll_cnt", coll_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    mon_en = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (a_rvalid) begin
          if (exp_a_q.size() == 0) check("a_rvalid_unexpected", 1, 0);
          else check("a_rdata", a_rdata, exp_a_q.pop_front());
        end
        if (b_rvalid) begin
          if (exp_b_q.size() == 0) check("b_rvalid_unexpected", 1, 0);
          else check("b_rdata", b_rdata, exp_b_q.pop_front());
        end
        check("coll_cnt", coll_cnt, (m_coll > CMAX) ? CMAX : m_coll);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic          r_ar, r_aw, r_br, r_bw;
  logic [AW-1:0] r_aa, r_ba;
  logic [DW-1:0] r_ad, r_bd;

  initial begin
    n_checks = 0; n_errors = 0; mon_en = 1'b0;
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    m_last_b = 1'b1; m_coll = 0; m_a_stall = 1'b0; m_b_stall = 1'b0;

    do_reset();

    // Fill every word so later reads have defined data.
    cycle(1'b1, 1'b1, 2'd0, 4'h9, 1'b1, 1'b1, 2'd1, 4'h4);
    // Non-colliding dual write, then read both back.
    cycle(1'b1, 1'b1, 2'd2, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b0010);
    cycle(1'b1, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0);
    idle();

    // Write/write collision at addr 3 with held requests.
    do_reset();
    cycle(1'b1, 1'b1, 2'd3, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b0110);
    cycle(1'b0, 1'b0, 2'd0, 4'h0, m_b_stall, 1'b1, 2'd3, 4'b0110);
    cycle(1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
    idle();

    // A keeps colliding on addr 3 while B holds a write there.
    cycle(1'b1, 1'b1, 2'd3, 4'h1, 1'b1, 1'b1, 2'd3, 4'hc);
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 1'b1, 2'd3, DW'(k + 2), m_b_stall, 1'b1, 2'd3, 4'hc);
    cycle(1'b0, 1'b0, 2'd0, 4'h0, m_b_stall, 1'b1, 2'd3, 4'hc);
    cycle(1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
    idle();

    // Read/write collision at addr 1 right after reset, then a second collision.
    do_reset();
    cycle(1'b1, 1'b0, 2'd1, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0101);
    cycle(1'b1, 1'b0, 2'd1, 4'h0, m_b_stall, 1'b1, 2'd1, 4'b0101);
    cycle(1'b0, 1'b0, 2'd0, 4'h0, m_b_stall, 1'b1, 2'd1, 4'b0101);
    cycle(1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
    idle();

    // Same-address dual read: both granted, no collision counted.
    cycle(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0);
    idle();

    // Saturation: five collision cycles on addr 2.
    do_reset();
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 1'b1, 2'd2, 4'h7, 1'b1, 1'b1, 2'd2, 4'h8);
    idle();
    idle();

    // Random traffic honouring the stalled-requester hold rule.
    do_reset();
    r_ar = 1'b0; r_aw = 1'b0; r_aa = '0; r_ad = '0;
    r_br = 1'b0; r_bw = 1'b0; r_ba = '0; r_bd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!m_a_stall) begin
        r_ar = ($urandom_range(0, 3) != 0);
        r_aw = 1'($urandom_range(0, 1));
        r_aa = AW'($urandom_range(0, DEPTH - 1));
        r_ad = DW'($urandom_range(0, (1 << DW) - 1));
      end
      if (!m_b_stall) begin
        r_br = ($urandom_range(0, 3) != 0);
        r_bw = 1'($urandom_range(0, 1));
        r_ba = AW'($urandom_range(0, DEPTH - 1));
        r_bd = DW'($urandom_range(0, (1 << DW) - 1));
      end
      cycle(r_ar, r_aw, r_aa, r_ad, r_br, r_bw, r_ba, r_bd);
    end
    idle();
    idle();
    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);

    // Reset in the middle of traffic clears the saturated counter.
    do_reset();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
